fir_decim_buffer: RTL and testbench
===================================

Name: fir_decim_buffer

Overview:
Downstream stage of the FIR filter. Takes the filter's out_sample/out_valid stream, keeps every DECIM-th valid sample, and buffers the kept samples in a small first-word-fall-through FIFO. The buffered samples go to the consumer over a valid/ready handshake. The FIR output cannot be stalled, so this block absorbs consumer backpressure and flags any sample it loses.

Parameters:
DATA_WIDTH, 16, sample width; matches the FIR output width
DECIM, 2, decimation factor, >=1; 1 keeps every valid sample
DEPTH, 8, FIFO depth in samples; power of two, >=2
AW, log2(DEPTH), derived pointer width; not user-set

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, synchronous, active-low
in_sample  input  DATA_WIDTH  signed sample from the FIR out_sample
in_valid  input  1  qualifies in_sample (FIR out_valid); single-cycle strobes, no backpressure
out_data  output  DATA_WIDTH  signed head-of-FIFO sample
out_valid  output  1  FIFO non-empty
out_ready  input  1  consumer accepts out_data this cycle
level  output  AW+1  current FIFO occupancy, 0..DEPTH
overflow  output  1  sticky flag: a kept sample was dropped because the FIFO was full
clr_ovf  input  1  clears overflow

Behaviour:
- One clock, clk. All state updates on the rising edge of clk. Reset is synchronous, active-low on rst_n.
- Reset (rst_n=0 at a clock edge):
  - phase=0, wr_ptr=0, rd_ptr=0, level=0, overflow=0.
  - out_valid=0, out_data=0.
  - FIFO memory is not reset.
  - Reset asserted mid-stream discards buffered samples; the first in_valid after reset is kept.
- Decimation phase counter, range 0..DECIM-1:
  - Increments on each in_valid and wraps DECIM-1 -> 0.
  - keep = in_valid && (phase==0).
  - in_sample is ignored when in_valid=0; phase holds.
  - DECIM=1: keep = in_valid.
- Push and pop:
  - push = keep && (!full || pop).
  - pop = out_valid && out_ready.
  - full = (level==DEPTH); empty = (level==0).
- FIFO write/read:
  - On push: mem[wr_ptr] <= in_sample; wr_ptr increments modulo DEPTH.
  - On pop: rd_ptr increments modulo DEPTH.
  - Pointers are AW bits and wrap naturally.
- Level update:
  - push&&!pop: +1.
  - pop&&!push: -1.
  - both or neither: unchanged.
  - Full with keep and pop in the same cycle: the write is accepted and level stays DEPTH.
- Overflow:
  - A drop is keep && full && !pop. The sample is discarded; pointers and level are unchanged; overflow <= 1 next edge.
  - phase still advances on a dropped sample, so decimation alignment is preserved.
  - clr_ovf=1 clears overflow at the next edge. If a drop and clr_ovf occur in the same cycle, set wins.
- Output, first-word-fall-through:
  - out_valid = !empty, derived from the registered level.
  - out_data = mem[rd_ptr] when out_valid, else 0.
  - Latency: a sample kept at edge N is visible with out_valid=1 from edge N onward, i.e. usable in the cycle after the in_valid cycle.
- Pop with empty FIFO: cannot occur, since pop requires out_valid. out_ready while empty is ignored.
- Consumer contract: out_data is stable while out_valid=1 and out_ready=0.
- Widths: data passes through unchanged; no arithmetic on samples. Sign is preserved bit-exactly.
- Implementation: a single registered level counter; no combinational path from in_valid to out_valid.

Test Plan:
- Decimation order. DECIM=2, out_ready=1. Drive in_valid every cycle with samples 10,20,30,40,50,60 -> out_data sequence is 10,30,50. Each appears one cycle after its input. level never exceeds 1.
- Sparse input. DECIM=2. in_valid pulses every 3rd cycle with samples 100,-100,200,-200 -> outputs are 100,200. phase holds between pulses. Sign is preserved: -100 is dropped by decimation, not corrupted.
- Fill to full and overflow. DECIM=1, DEPTH=8, out_ready=0. Push samples 1..10 -> level reaches 8. overflow=1 from the edge after sample 9. Samples 9 and 10 are dropped. Raising out_ready then drains 1..8 in order, and level returns to 0.
- Full with simultaneous push/pop. FIFO full with 1..8. In the same cycle keep=1 with sample 99 and out_ready=1 -> sample 1 is popped, 99 is written, level stays 8, overflow stays 0. Drain order is 2..8,99.
- Overflow clear priority. Overflow already set. Assert clr_ovf in the same cycle as another drop -> overflow stays 1. Assert clr_ovf with no drop -> overflow=0 next cycle.
- Reset mid-operation. With level=5 and phase=1, pulse rst_n low for one edge -> at that edge level=0, out_valid=0, out_data=0, overflow=0. The next in_valid sample (e.g. 7) is kept and output.

Source files
------------

// File: rtl/fir_decim_buffer.sv
// rtl/fir_decim_buffer.sv - keeps every DECIM-th FIR sample and buffers it in a FWFT FIFO
module fir_decim_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int DECIM      = 2,
    parameter int DEPTH      = 8,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic signed [DATA_WIDTH-1:0] in_sample,
    input  logic                         in_valid,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [AW:0]                  level,
    output logic                         overflow,
    input  logic                         clr_ovf
);
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(DECIM - 1);
    localparam logic [AW:0]   LEVEL_FULL = (AW + 1)'(DEPTH);

    logic [PW-1:0]                phase;
    logic [AW-1:0]                wr_ptr;
    logic [AW-1:0]                rd_ptr;
    logic signed [DATA_WIDTH-1:0] mem [DEPTH];

    logic keep;
    logic push;
    logic pop;
    logic full;
    logic empty;
    logic drop;

    // Everything visible downstream comes from registered state only.
    always_comb begin
        full      = (level == LEVEL_FULL);
        empty     = (level == '0);
        out_valid = !empty;
        pop       = out_valid && out_ready;
        keep      = in_valid && (phase == '0);
        push      = keep && (!full || pop);
        drop      = keep && full && !pop;
        out_data  = out_valid ? mem[rd_ptr] : '0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_sample;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            // Phase advances on every valid, dropped or not, to keep alignment.
            if (in_valid) begin
                phase <= (phase == PHASE_LAST) ? '0 : phase + 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fir_decim_buffer.sv
// tb/tb_fir_decim_buffer.sv - scenario bench for fir_decim_buffer against a queue model
module tb_fir_decim_buffer;
    localparam int DW    = 16;
    localparam int DECIM = 2;
    localparam int DEPTH = 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic signed [DW-1:0] in_sample = '0;
    logic                 in_valid = 1'b0;
    logic signed [DW-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [3:0]           level;
    logic                 overflow;
    logic                 clr_ovf = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic signed [DW-1:0] m_q[$];
    int                   m_cnt = 0;
    logic                 m_ovf = 1'b0;
    logic signed [DW-1:0] got[$];

    fir_decim_buffer #(.DATA_WIDTH(DW), .DECIM(DECIM), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_sample(in_sample), .in_valid(in_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .level(level), .overflow(overflow), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    // Reference: valid count modulo DECIM picks kept samples; a queue holds them.
    task automatic model_edge(input bit v, input logic signed [DW-1:0] s, input bit r, input bit c);
        bit keep, pop, full, drop;
        pop  = (m_q.size() != 0) && r;
        keep = v && ((m_cnt % DECIM) == 0);
        full = (m_q.size() == DEPTH);
        drop = keep && full && !pop;
        if (v) m_cnt++;
        if (pop) void'(m_q.pop_front());
        if (keep && !drop) m_q.push_back(s);
        if (drop) m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
    endtask

    task automatic step(input bit v, input int s, input bit r, input bit c);
        @(negedge clk);
        rst_n = 1'b1; in_valid = v; in_sample = 16'(s); out_ready = r; clr_ovf = c;
        #1;
        if (out_valid && r) got.push_back(out_data);
        @(posedge clk);
        model_edge(v, 16'(s), r, c);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
        @(posedge clk);
        m_q.delete(); m_cnt = 0; m_ovf = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (level !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", level); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        n_tests++; if (out_data !== 16'sd0) begin n_fail++; $display("FAIL reset_data: got %0d expected 0", out_data); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
    endtask

    task automatic test_decim_order();
        int exp_d[3] = '{10, 30, 50};
        logic signed [DW-1:0] e;
        got.delete();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, (i + 1) * 10, 1'b1, 1'b0);
            e = 16'((i + 1) * 10);
            n_tests++;
            if (level > 4'd1) begin n_fail++; $display("FAIL decim_level: got %0d expected <=1", level); end
            n_tests++;
            if ((i % 2) == 0 && (out_valid !== 1'b1 || out_data !== e)) begin
                n_fail++; $display("FAIL decim_latency: got v=%b d=%0d expected v=1 d=%0d", out_valid, out_data, e);
            end else if ((i % 2) == 1 && out_valid !== 1'b0) begin
                n_fail++; $display("FAIL decim_skip: got v=%b expected v=0", out_valid);
            end
        end
        step(1'b0, 0, 1'b1, 1'b0);
        n_tests++;
        if (got.size() != 3) begin n_fail++; $display("FAIL decim_count: got %0d expected 3", got.size()); end
        for (int k = 0; k < 3 && k < got.size(); k++) begin
            e = 16'(exp_d[k]);
            n_tests++;
            if (got[k] !== e) begin n_fail++; $display("FAIL decim_seq[%0d]: got %0d expected %0d", k, got[k], e); end
        end
    endtask

    task automatic test_sparse();
        int sv[4] = '{100, -100, 200, -200};
        logic signed [DW-1:0] e0, e1;
        e0 = 16'sd100; e1 = 16'sd200;
        got.delete();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, sv[i], 1'b1, 1'b0);
            step(1'b0, 12345, 1'b1, 1'b0);
            step(1'b0, -777, 1'b1, 1'b0);
        end
        n_tests++;
        if (got.size() != 2) begin n_fail++; $display("FAIL sparse_count: got %0d expected 2", got.size()); end
        if (got.size() == 2) begin
            n_tests++; if (got[0] !== e0) begin n_fail++; $display("FAIL sparse_0: got %0d expected %0d", got[0], e0); end
            n_tests++; if (got[1] !== e1) begin n_fail++; $display("FAIL sparse_1: got %0d expected %0d", got[1], e1); end
        end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, i, 1'b0, 1'b0);
            if (i == 8) begin
                n_tests++; if (level !== 4'd8) begin n_fail++; $display("FAIL ovf_full_level: got %0d expected 8", level); end
                n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b expected 0", overflow); end
            end
            if (i == 9) begin
                n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", overflow); end
            end
            step(1'b1, 1000 + i, 1'b0, 1'b0);
        end
        n_tests++; if (level !== 4'd8) begin n_fail++; $display("FAIL ovf_level: got %0d expected 8", level); end
        n_tests++; if (out_data !== 16'sd1) begin n_fail++; $display("FAIL ovf_head: got %0d expected 1", out_data); end
    endtask

    task automatic test_clr_priority();
        step(1'b1, 500, 1'b0, 1'b1);
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL clr_vs_drop: got %b expected 1", overflow); end
        step(1'b1, 501, 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b1);
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL clr_plain: got %b expected 0", overflow); end
        n_tests++; if (level !== 4'd8) begin n_fail++; $display("FAIL clr_level: got %0d expected 8", level); end
    endtask

    task automatic test_drain_1_to_8();
        logic signed [DW-1:0] e;
        got.delete();
        for (int i = 0; i < 9; i++) step(1'b0, 0, 1'b1, 1'b0);
        n_tests++; if (level !== 4'd0) begin n_fail++; $display("FAIL drain_level: got %0d expected 0", level); end
        n_tests++; if (got.size() != 8) begin n_fail++; $display("FAIL drain_count: got %0d expected 8", got.size()); end
        for (int k = 0; k < 8 && k < got.size(); k++) begin
            e = 16'(k + 1);
            n_tests++;
            if (got[k] !== e) begin n_fail++; $display("FAIL drain_seq[%0d]: got %0d expected %0d", k, got[k], e); end
        end
    endtask

    task automatic test_full_push_pop();
        logic signed [DW-1:0] e;
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, i, 1'b0, 1'b0);
            step(1'b1, -i, 1'b0, 1'b0);
        end
        n_tests++; if (level !== 4'd8) begin n_fail++; $display("FAIL pp_prefill: got %0d expected 8", level); end
        got.delete();
        step(1'b1, 99, 1'b1, 1'b0);
        n_tests++; if (level !== 4'd8) begin n_fail++; $display("FAIL pp_level: got %0d expected 8", level); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL pp_ovf: got %b expected 0", overflow); end
        n_tests++; if (out_data !== 16'sd2) begin n_fail++; $display("FAIL pp_head: got %0d expected 2", out_data); end
        step(1'b1, 77, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b0, 0, 1'b1, 1'b0);
        n_tests++; if (got.size() != 9) begin n_fail++; $display("FAIL pp_count: got %0d expected 9", got.size()); end
        for (int k = 0; k < 9 && k < got.size(); k++) begin
            e = (k == 8) ? 16'sd99 : 16'(k + 1);
            n_tests++;
            if (got[k] !== e) begin n_fail++; $display("FAIL pp_seq[%0d]: got %0d expected %0d", k, got[k], e); end
        end
    endtask

    task automatic test_random();
        bit v, r, c;
        int s;
        logic signed [DW-1:0] e;
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 3) != 0);
            r = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 7) == 0);
            s = int'($urandom);
            step(v, s, r, c);
            e = (m_q.size() != 0) ? m_q[0] : 16'sd0;
            n_tests++;
            if (level !== 4'(m_q.size()) || out_valid !== (m_q.size() != 0) ||
                out_data !== e || overflow !== m_ovf) begin
                n_fail++;
                $display("FAIL rand[%0d]: got lvl=%0d v=%b d=%0d ovf=%b expected lvl=%0d v=%b d=%0d ovf=%b",
                         i, level, out_valid, out_data, overflow, m_q.size(), (m_q.size() != 0), e, m_ovf);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, i, 1'b0, 1'b0);
            step(1'b1, 50 + i, 1'b0, 1'b0);
        end
        step(1'b1, 5, 1'b0, 1'b0);
        n_tests++; if (level !== 4'd5) begin n_fail++; $display("FAIL mid_prefill: got %0d expected 5", level); end
        do_reset();
        n_tests++; if (level !== 4'd0) begin n_fail++; $display("FAIL mid_level: got %0d expected 0", level); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b expected 0", out_valid); end
        n_tests++; if (out_data !== 16'sd0) begin n_fail++; $display("FAIL mid_data: got %0d expected 0", out_data); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL mid_ovf: got %b expected 0", overflow); end
        step(1'b1, 7, 1'b0, 1'b0);
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 16'sd7) begin
            n_fail++; $display("FAIL mid_first: got v=%b d=%0d expected v=1 d=7", out_valid, out_data);
        end
        step(1'b0, 0, 1'b1, 1'b0);
        n_tests++; if (level !== 4'd0) begin n_fail++; $display("FAIL mid_drain: got %0d expected 0", level); end
    endtask

    initial begin
        test_reset();
        test_decim_order();
        test_sparse();
        test_overflow();
        test_clr_priority();
        test_drain_1_to_8();
        test_full_push_pop();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
